interface_hcsr04_param: RTL and testbench

Parametrised successor of the HC-SR04 ultrasonic interface. Issues the trigger pulse, times the echo and outputs distance in centimetres as saturating BCD, with round-to-nearest. Adds echo timeout detection and a free-running continuous mode. Sits between the top-level sensor pins and the measurement/display datapath; the `medir`/`pronto` handshake is unchanged.

---
 rtl/interface_hcsr04_param_pkg.sv | 17 +
 rtl/interface_hcsr04_param_contador_bcd_sat.sv | 22 ++
 rtl/interface_hcsr04_param.sv | 106 ++++++++++
 tb/tb_interface_hcsr04_param.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/interface_hcsr04_param_pkg.sv
// interface_hcsr04_param_pkg: state codes and µs-to-clock conversion shared by the HC-SR04 interface
package interface_hcsr04_param_pkg;
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARACAO     = 4'd1,
    ENVIA_TRIGGER  = 4'd2,
    ESPERA_ECHO    = 4'd3,
    MEDIDA         = 4'd4,
    ARMAZENAMENTO  = 4'd5,
    FINAL_MEDIDA   = 4'd6,
    ERRO           = 4'd7,
    ESPERA_PERIODO = 4'd8
  } estado_t;
  function automatic int us_para_clk(input int clk_hz, input int us);
    return clk_hz / 1_000_000 * us;
  endfunction
endpackage

// File: rtl/interface_hcsr04_param_contador_bcd_sat.sv
// contador_bcd_sat: DIGITS-wide cascaded BCD counter saturating at all 9s; ports clock, limpa (sync clear), habilita -> valor, soma (saturating next value), maximo
module contador_bcd_sat #(
  parameter int DIGITS = 3
) (
  input  logic                clock,
  input  logic                limpa,
  input  logic                habilita,
  output logic [4*DIGITS-1:0] valor,
  output logic [4*DIGITS-1:0] soma,
  output logic                maximo
);
  logic [DIGITS:0] vai;
  assign vai[0] = 1'b1;
  assign maximo = vai[DIGITS];
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign vai[g+1] = vai[g] && valor[4*g+:4] == 4'h9;
    assign soma[4*g+:4] = (maximo || !vai[g]) ? valor[4*g+:4] :
                          (valor[4*g+:4] == 4'h9) ? 4'h0 : valor[4*g+:4] + 4'h1;
  end
  always_ff @(posedge clock)
    valor <= limpa ? '0 : habilita ? soma : valor;
endmodule

// File: rtl/interface_hcsr04_param.sv
// interface_hcsr04_param: HC-SR04 trigger/echo timer giving rounded saturating BCD cm with timeout and continuous mode; ports clock, reset, medir, continuo, echo -> trigger, medida, pronto, timeout, db_estado; define ECHO_SYNC_EN for a 2-flop echo synchronizer
module interface_hcsr04_param
  import interface_hcsr04_param_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIGGER_US = 10,
  parameter int TIMEOUT_US = 30_000,
  parameter int PERIOD_US  = 100_000,
  parameter int CM_TICKS   = 2941,
  parameter int DIGITS     = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                medir,
  input  logic                continuo,
  input  logic                echo,
  output logic                trigger,
  output logic [4*DIGITS-1:0] medida,
  output logic                pronto,
  output logic                timeout,
  output logic [3:0]          db_estado
);
  localparam int TRIG_CLK = us_para_clk(CLK_HZ, TRIGGER_US);
  localparam int TO_CLK   = us_para_clk(CLK_HZ, TIMEOUT_US);
  localparam int PER_CLK  = us_para_clk(CLK_HZ, PERIOD_US);
  localparam int TW = $clog2((TO_CLK > TRIG_CLK ? TO_CLK : TRIG_CLK) + 1);
  localparam int KW = $clog2(CM_TICKS + 1);
  localparam int PW = $clog2(PER_CLK + 1);
  localparam logic [TW-1:0] TRIG_FIM  = TW'(TRIG_CLK - 1);
  localparam logic [TW-1:0] TO_FIM    = TW'(TO_CLK - 1);
  localparam logic [KW-1:0] TICK_FIM  = KW'(CM_TICKS - 1);
  localparam logic [KW-1:0] TICK_MEIO = KW'(CM_TICKS / 2);
  localparam logic [PW-1:0] PER_FIM   = PW'(PER_CLK - 2);
  localparam logic [PW-1:0] PER_MAX   = PW'(PER_CLK);
  estado_t             estado, proximo;
  logic                eco, maximo, timeout_r, conta_cm, limpa;
  logic [TW-1:0]       tempo;
  logic [KW-1:0]       tick;
  logic [PW-1:0]       periodo;
  logic [4*DIGITS-1:0] valor, soma, medida_r;
`ifdef ECHO_SYNC_EN
  logic [1:0] eco_sinc;
  always_ff @(posedge clock)
    eco_sinc <= reset ? 2'b00 : {eco_sinc[0], echo};
  assign eco = eco_sinc[1];
`else
  assign eco = echo;
`endif
  always_ff @(posedge clock)
    estado <= reset ? INICIAL : proximo;
  // PER_FIM is two short of the period: preparacao and the trigger's first cycle follow
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:        proximo = (medir || continuo) ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo = ENVIA_TRIGGER;
      ENVIA_TRIGGER:  proximo = (tempo == TRIG_FIM) ? ESPERA_ECHO : ENVIA_TRIGGER;
      ESPERA_ECHO:    proximo = eco ? MEDIDA : (tempo == TO_FIM) ? ERRO : ESPERA_ECHO;
      MEDIDA:         proximo = !eco ? ARMAZENAMENTO : (tempo == TO_FIM) ? ERRO : MEDIDA;
      ARMAZENAMENTO:  proximo = FINAL_MEDIDA;
      FINAL_MEDIDA,
      ERRO:           proximo = continuo ? ESPERA_PERIODO : INICIAL;
      ESPERA_PERIODO: proximo = !continuo ? INICIAL : (periodo >= PER_FIM) ? PREPARACAO : ESPERA_PERIODO;
      default:        proximo = INICIAL;
    endcase
  end
  always_comb begin
    trigger   = estado == ENVIA_TRIGGER;
    pronto    = estado == FINAL_MEDIDA || estado == ERRO;
    timeout   = timeout_r || estado == ERRO;
    medida    = medida_r;
    db_estado = estado;
  end
  // medida counts its exit cycle too, so the measured width equals the echo-high width
  always_ff @(posedge clock) begin
    if (reset) begin
      tempo     <= '0;
      tick      <= '0;
      periodo   <= '0;
      medida_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      tempo   <= (estado != proximo) ? '0 : tempo + 1'b1;
      tick    <= (estado == PREPARACAO) ? '0 :
                 (estado == MEDIDA) ? ((tick == TICK_FIM) ? '0 : tick + 1'b1) : tick;
      periodo <= (estado == PREPARACAO) ? '0 :
                 (estado == INICIAL || periodo == PER_MAX) ? periodo : periodo + 1'b1;
      if (estado == ARMAZENAMENTO) begin
        medida_r  <= (tick > TICK_MEIO) ? soma : valor;
        timeout_r <= 1'b0;
      end
      if (estado == ERRO)
        timeout_r <= 1'b1;
    end
  end
  assign conta_cm = estado == MEDIDA && tick == TICK_FIM;
  assign limpa    = reset || estado == PREPARACAO;
  contador_bcd_sat #(.DIGITS(DIGITS)) u_bcd (
    .clock    (clock),
    .limpa    (limpa),
    .habilita (conta_cm),
    .valor    (valor),
    .soma     (soma),
    .maximo   (maximo)
  );
endmodule

// File: tb/tb_interface_hcsr04_param.sv
// tb_interface_hcsr04_param: directed checks of trigger timing, rounding, saturation, timeouts, continuous mode and reset
module tb_interface_hcsr04_param;
  logic        clock = 1'b0, reset = 1'b1, medir = 1'b0, continuo = 1'b0, echo = 1'b0;
  logic        trigger, pronto, timeout, trigger_s, pronto_s, timeout_s;
  logic [11:0] medida;
  logic [3:0]  medida_s, db_estado, db_s;
  int          checks = 0, errors = 0, cyc = 0, viol = 0;
  interface_hcsr04_param #(
    .CLK_HZ(2_000_000), .TRIGGER_US(5), .TIMEOUT_US(200), .PERIOD_US(300), .CM_TICKS(10), .DIGITS(3)
  ) dut (
    .clock(clock), .reset(reset), .medir(medir), .continuo(continuo), .echo(echo),
    .trigger(trigger), .medida(medida), .pronto(pronto), .timeout(timeout), .db_estado(db_estado)
  );
  interface_hcsr04_param #(
    .CLK_HZ(2_000_000), .TRIGGER_US(5), .TIMEOUT_US(200), .PERIOD_US(300), .CM_TICKS(10), .DIGITS(1)
  ) dut_s (
    .clock(clock), .reset(reset), .medir(medir), .continuo(continuo), .echo(echo),
    .trigger(trigger_s), .medida(medida_s), .pronto(pronto_s), .timeout(timeout_s), .db_estado(db_s)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (pronto && trigger) viol <= viol + 1;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic eco(input int w, output int n);
    if (w > 0) begin
      tick();
      tick();
      echo = 1'b1;
      for (int i = 0; i < w && !pronto; i++) tick();
      echo = 1'b0;
    end
    n = 0;
    while (!pronto && n < 1000) begin
      tick();
      n++;
    end
  endtask
  task automatic medir_uma(input string nome, input int w, input logic [11:0] em, input logic et, input int elat);
    int lat, larg, n;
    medir = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      medir = 1'b0;
    end while (!trigger && lat < 20);
    check({nome, "_trig_lat"}, lat, 2);
    larg = 0;
    while (trigger && larg < 100) begin
      tick();
      larg++;
    end
    check({nome, "_trig_w"}, larg, 10);
    eco(w, n);
    check({nome, "_pronto_lat"}, n, elat);
    check({nome, "_medida"}, medida, em);
    check({nome, "_timeout"}, timeout, et);
    tick();
    check({nome, "_pronto_1c"}, pronto, 0);
    check({nome, "_estado"}, db_estado, 0);
  endtask
  initial begin
    int t, t1, t2, n;
    repeat (3) tick();
    check("rst_estado", db_estado, 0);
    check("rst_trigger", trigger, 0);
    check("rst_medida", medida, 0);
    check("rst_pronto", pronto, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
    tick();
    medir_uma("m5", 47, 12'h005, 0, 2);
    medir_uma("m12", 125, 12'h012, 0, 2);
    medir_uma("m13", 126, 12'h013, 0, 2);
    medir_uma("to", 0, 12'h013, 1, 400);
    check("to_held", timeout, 1);
    medir_uma("m5b", 47, 12'h005, 0, 2);
    medir_uma("toeco", 1000, 12'h005, 1, 0);
    medir_uma("m15", 150, 12'h015, 0, 2);
    check("sat_medida", medida_s, 4'h9);
    check("sat_timeout", timeout_s, 0);
    continuo = 1'b1;
    t = 0;
    while (!trigger && t < 20) begin tick(); t++; end
    check("cont_trig1", trigger, 1);
    t1 = cyc;
    while (trigger && t < 100) begin tick(); t++; end
    eco(47, n);
    check("cont1_lat", n, 2);
    check("cont1_medida", medida, 12'h005);
    tick();
    check("cont1_espera", db_estado, 8);
    t = 0;
    while (!trigger && t < 800) begin tick(); t++; end
    check("cont_trig2", trigger, 1);
    t2 = cyc;
    check("cont_periodo", t2 - t1, 600);
    t = 0;
    while (trigger && t < 100) begin tick(); t++; end
    eco(47, n);
    check("cont2_lat", n, 2);
    check("cont2_medida", medida, 12'h005);
    tick();
    check("cont2_espera", db_estado, 8);
    continuo = 1'b0;
    tick();
    check("cont_para", db_estado, 0);
    n = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (trigger) n++;
    end
    check("cont_sem_trig", n, 0);
    medir = 1'b1;
    tick();
    medir = 1'b0;
    t = 0;
    while (!trigger && t < 20) begin tick(); t++; end
    while (trigger && t < 100) begin tick(); t++; end
    tick();
    echo = 1'b1;
    repeat (5) tick();
    check("rm_estado_medida", db_estado, 4);
    reset = 1'b1;
    tick();
    check("rm_estado", db_estado, 0);
    check("rm_trigger", trigger, 0);
    check("rm_medida", medida, 0);
    check("rm_pronto", pronto, 0);
    check("rm_timeout", timeout, 0);
    reset = 1'b0;
    echo = 1'b0;
    tick();
    medir_uma("pos_rst", 47, 12'h005, 0, 2);
    check("pronto_trigger", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
